// File: rtl/dwc_ddrphy_por_seq.sv
// Core-domain sequencer for the PHY power-on-reset / DRAM-reset handoff cell.
// Issues the DCTSane set pulse, confirms DCTSane, releases POR MemReset, then owns DCTMemReset.
module dwc_ddrphy_por_seq #(
    parameter int SETTLE_CYC  = 16,
    parameter int PULSE_CYC   = 4,
    parameter int SANE_TMO    = 64,
    parameter int MIN_RST_CYC = 32,
    parameter int CNT_W       = 8
) (
    input  logic       DfiClk,
    input  logic       Reset_n,
    input  logic       PwrOkDlyd,
    input  logic       DCTSane,
    input  logic       SeqStart,
    input  logic       MemResetReq,
    output logic       SetDCTSanePulse,
    output logic       ClrPORMemReset,
    output logic       DCTMemReset,
    output logic       SeqDone,
    output logic       SeqErr,
    output logic [2:0] SeqState
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PWROK = 3'd1,
        SETTLE     = 3'd2,
        SANE_PULSE = 3'd3,
        SANE_WAIT  = 3'd4,
        CLR_POR    = 3'd5,
        READY      = 3'd6,
        ERROR      = 3'd7
    } seqState_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LD   = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD    = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SANE_TMO_LD = CNT_W'(SANE_TMO - 1);
    localparam logic [CNT_W-1:0] MIN_RST_LD  = CNT_W'(MIN_RST_CYC - 1);

    logic             pwrOkMeta, pwrOkSync;
    logic             saneMeta, saneSync;
    seqState_t        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [CNT_W-1:0] holdCnt, holdCntNext;
    logic             pulseNext, clrNext, memRstNext, doneNext, errNext;
    logic             pwrLost;

    // Two-flop synchronisers for the asynchronous POR-cell inputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge DfiClk or negedge Reset_n) begin
        if (!Reset_n) begin
            pwrOkMeta <= 1'b0;
            pwrOkSync <= 1'b0;
            saneMeta  <= 1'b0;
            saneSync  <= 1'b0;
        end else begin
            pwrOkMeta <= PwrOkDlyd;
            pwrOkSync <= pwrOkMeta;
            saneMeta  <= DCTSane;
            saneSync  <= saneMeta;
        end
    end

    assign pwrLost = !pwrOkSync &&
                     (state inside {SETTLE, SANE_PULSE, SANE_WAIT, CLR_POR, READY});

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        stateNext   = state;
        cntNext     = (cnt != '0) ? cnt - CNT_ONE : '0;
        holdCntNext = (holdCnt != '0) ? holdCnt - CNT_ONE : '0;
        memRstNext  = 1'b1;

        // Power loss outranks every other exit, including the timeout and sane result.
        if (pwrLost) begin
            stateNext = WAIT_PWROK;
        end else begin
            unique case (state)
                IDLE: begin
                    if (SeqStart) stateNext = WAIT_PWROK;
                end
                WAIT_PWROK: begin
                    if (pwrOkSync) begin
                        stateNext = SETTLE;
                        cntNext   = SETTLE_LD;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        stateNext = SANE_PULSE;
                        cntNext   = PULSE_LD;
                    end
                end
                SANE_PULSE: begin
                    if (cnt == '0) begin
                        stateNext = SANE_WAIT;
                        cntNext   = SANE_TMO_LD;
                    end
                end
                SANE_WAIT: begin
                    if (saneSync)        stateNext = CLR_POR;
                    else if (cnt == '0)  stateNext = ERROR;
                end
                CLR_POR: begin
                    stateNext = READY;
                end
                READY: begin
                    if (!saneSync) stateNext = ERROR;
                end
                ERROR: begin
                    if (SeqStart) stateNext = WAIT_PWROK;
                end
                default: stateNext = IDLE;
            endcase
        end

        // A release request is deferred until the minimum assertion time has elapsed.
        if (state == READY && stateNext == READY) begin
            if (MemResetReq) begin
                memRstNext = 1'b1;
                if (!DCTMemReset) holdCntNext = MIN_RST_LD;
            end else begin
                memRstNext = DCTMemReset && (holdCnt != '0);
            end
        end

        pulseNext = (stateNext == SANE_PULSE);
        clrNext   = (stateNext == CLR_POR) || (stateNext == READY);
        doneNext  = (stateNext == READY);
        errNext   = (stateNext == ERROR);
    end

    always_ff @(posedge DfiClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            holdCnt         <= '0;
            SetDCTSanePulse <= 1'b0;
            ClrPORMemReset  <= 1'b0;
            DCTMemReset     <= 1'b1;
            SeqDone         <= 1'b0;
            SeqErr          <= 1'b0;
        end else begin
            state           <= stateNext;
            cnt             <= cntNext;
            holdCnt         <= holdCntNext;
            SetDCTSanePulse <= pulseNext;
            ClrPORMemReset  <= clrNext;
            DCTMemReset     <= memRstNext;
            SeqDone         <= doneNext;
            SeqErr          <= errNext;
        end
    end

    assign SeqState = state;

endmodule

// File: tb/tb_dwc_ddrphy_por_seq.sv
// Randomised bench for dwc_ddrphy_por_seq, compared every cycle against a phase/age
// reference model derived from the sequencing rules.
module tb_dwc_ddrphy_por_seq;

    localparam int SETTLE_CYC  = 16;
    localparam int PULSE_CYC   = 4;
    localparam int SANE_TMO    = 64;
    localparam int MIN_RST_CYC = 32;

    logic       DfiClk;
    logic       Reset_n;
    logic       PwrOkDlyd, DCTSane, SeqStart, MemResetReq;
    logic       SetDCTSanePulse, ClrPORMemReset, DCTMemReset, SeqDone, SeqErr;
    logic [2:0] SeqState;

    dwc_ddrphy_por_seq #(
        .SETTLE_CYC (SETTLE_CYC),
        .PULSE_CYC  (PULSE_CYC),
        .SANE_TMO   (SANE_TMO),
        .MIN_RST_CYC(MIN_RST_CYC),
        .CNT_W      (8)
    ) dut (
        .DfiClk         (DfiClk),
        .Reset_n        (Reset_n),
        .PwrOkDlyd      (PwrOkDlyd),
        .DCTSane        (DCTSane),
        .SeqStart       (SeqStart),
        .MemResetReq    (MemResetReq),
        .SetDCTSanePulse(SetDCTSanePulse),
        .ClrPORMemReset (ClrPORMemReset),
        .DCTMemReset    (DCTMemReset),
        .SeqDone        (SeqDone),
        .SeqErr         (SeqErr),
        .SeqState       (SeqState)
    );

    initial DfiClk = 1'b0;
    always #5 DfiClk = ~DfiClk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase number, cycles spent in phase, raw-input history for the
    // two-cycle sync latency, and the absolute cycle at which DRAM reset was last asserted.
    int     mPhase, mAge;
    bit     mPw0, mPw1, mSa0, mSa1;
    bit     mMemRst;
    longint mAssertCyc, cyc;

    function automatic void modelReset();
        mPhase = 0; mAge = 0;
        mPw0 = 0; mPw1 = 0; mSa0 = 0; mSa1 = 0;
        mMemRst = 1; mAssertCyc = -100000;
    endfunction

    function automatic void modelStep();
        bit pwS = mPw1;
        bit saS = mSa1;
        int nxt = mPhase;
        if (mPhase >= 2 && mPhase <= 6 && !pwS) nxt = 1;
        else begin
            case (mPhase)
                0: if (SeqStart) nxt = 1;
                1: if (pwS) nxt = 2;
                2: if (mAge == SETTLE_CYC - 1) nxt = 3;
                3: if (mAge == PULSE_CYC - 1) nxt = 4;
                4: if (saS) nxt = 5; else if (mAge == SANE_TMO - 1) nxt = 7;
                5: nxt = 6;
                6: if (!saS) nxt = 7;
                7: if (SeqStart) nxt = 1;
                default: nxt = 0;
            endcase
        end
        if (mPhase == 6 && nxt == 6) begin
            if (MemResetReq) begin
                if (!mMemRst) mAssertCyc = cyc;
                mMemRst = 1;
            end else if (!(mMemRst && (cyc - mAssertCyc) < MIN_RST_CYC)) begin
                mMemRst = 0;
            end
        end else begin
            mMemRst = 1;
        end
        mAge   = (nxt == mPhase) ? mAge + 1 : 0;
        mPhase = nxt;
        mPw1 = mPw0; mPw0 = PwrOkDlyd;
        mSa1 = mSa0; mSa0 = DCTSane;
    endfunction

    task automatic checkAll(input string tag);
        logic [2:0] expState;
        expState = mPhase[2:0];
        check({tag, ".pulse"}, SetDCTSanePulse, mPhase == 3);
        check({tag, ".clr"},   ClrPORMemReset,  mPhase == 5 || mPhase == 6);
        check({tag, ".mrst"},  DCTMemReset,     mMemRst);
        check({tag, ".done"},  SeqDone,         mPhase == 6);
        check({tag, ".err"},   SeqErr,          mPhase == 7);
        check({tag, ".state"}, SeqState,        expState);
    endtask

    // Episode knobs and stimulus state.
    bit idleNoise;
    int startRate, dropRate, saneDropRate, saneDelay, rstPhase;
    int pwrDelay, pwrLowLeft, reqLeft, rstHold;
    bit rstDone;

    task automatic step(input string tag);
        @(posedge DfiClk);
        if (Reset_n) modelStep();
        cyc++;
        @(negedge DfiClk);
        checkAll(tag);
    endtask

    task automatic drive();
        if (idleNoise) begin
            SeqStart    = 1'b0;
            PwrOkDlyd   = 1'($urandom);
            DCTSane     = 1'($urandom);
            MemResetReq = 1'($urandom);
            return;
        end
        SeqStart = 1'b0;
        if ((mPhase == 0 || mPhase == 7) && $urandom_range(0, startRate) == 0) SeqStart = 1'b1;
        else if ($urandom_range(0, 40) == 0) SeqStart = 1'b1;

        if (pwrDelay > 0) begin
            pwrDelay--; PwrOkDlyd = 1'b0;
        end else if (pwrLowLeft > 0) begin
            pwrLowLeft--; PwrOkDlyd = 1'b0;
        end else if (dropRate != 0 && $urandom_range(0, dropRate) == 0) begin
            pwrLowLeft = $urandom_range(0, 5); PwrOkDlyd = 1'b0;
        end else begin
            PwrOkDlyd = 1'b1;
        end

        case (mPhase)
            4: DCTSane = (mAge >= saneDelay);
            5: DCTSane = DCTSane;
            6: if (saneDropRate != 0 && $urandom_range(0, saneDropRate) == 0) DCTSane = 1'b0;
            default: DCTSane = 1'b0;
        endcase

        if (reqLeft == 0) begin
            MemResetReq = ~MemResetReq;
            case ($urandom_range(0, 3))
                0: reqLeft = $urandom_range(1, 5);
                1: reqLeft = $urandom_range(28, 36);
                2: reqLeft = $urandom_range(45, 55);
                default: reqLeft = $urandom_range(1, 15);
            endcase
        end else begin
            reqLeft--;
        end

        if (rstHold > 0) begin
            rstHold--;
            if (rstHold == 0) Reset_n = 1'b1;
        end else if (!rstDone && rstPhase == mPhase && mAge >= 5) begin
            rstDone = 1;
            #2 Reset_n = 1'b0;
            #1 modelReset();
            checkAll("arst");
            rstHold = 2;
        end
    endtask

    task automatic episode(input string tag, input int len, input int sRate, input int dRate,
                           input int sdRate, input int sDelay, input int rPhase, input int pDelay);
        startRate = sRate; dropRate = dRate; saneDropRate = sdRate;
        saneDelay = sDelay; rstPhase = rPhase; pwrDelay = pDelay;
        pwrLowLeft = 0; rstDone = 0;
        for (int i = 0; i < len; i++) begin
            drive();
            step(tag);
        end
    endtask

    initial begin
        int saneChoices[10] = '{0, 1, 3, 20, 60, 61, 62, 63, 64, 1000};
        Reset_n = 1'b0; PwrOkDlyd = 1'b0; DCTSane = 1'b0; SeqStart = 1'b0; MemResetReq = 1'b0;
        idleNoise = 0; reqLeft = 0; rstHold = 0; cyc = 0;
        modelReset();
        repeat (2) @(negedge DfiClk);
        checkAll("por");
        Reset_n = 1'b1;

        idleNoise = 1;
        for (int i = 0; i < 100; i++) begin
            drive();
            step("idle");
        end
        idleNoise = 0;
        check("idle.final_state", SeqState, 3'd0);

        episode("nominal",  400, 0,   0,  0,  3, -1, 5);
        episode("timeout",  120, 500, 0,  0,  1000, -1, 0);
        episode("restart",  200, 0,   0,  0,  3, -1, 0);
        episode("pwrdrop",  400, 2,   40, 0,  3, -1, 0);
        episode("rst_wait", 150, 0,   0,  0,  1000, 4, 0);
        episode("rst_err",  400, 20,  0,  0,  1000, 7, 0);
        episode("sanedrop", 300, 2,   0,  80, 2, -1, 0);

        for (int e = 0; e < 30; e++) begin
            episode("rand", $urandom_range(200, 500), $urandom_range(0, 10),
                    ($urandom_range(0, 1) != 0) ? $urandom_range(30, 300) : 0,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(50, 300) : 0,
                    saneChoices[$urandom_range(0, 9)],
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1,
                    $urandom_range(0, 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
